// File: rtl/logic_unit_pipe.sv
// Three-operand bitwise logic unit with a 2-entry in-order result buffer and a
// saturating counter of nonzero results handed to the consumer.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] hit_count
);

   function automatic logic [WIDTH-1:0] logic_op(
      input logic [1:0]       m,
      input logic [WIDTH-1:0] x0,
      input logic [WIDTH-1:0] x1,
      input logic [WIDTH-1:0] x2
   );
      logic [WIDTH-1:0] r;
      case (m)
         2'b00:   r = (x0 & x1) | x2;
         2'b01:   r = (x0 | x1) & x2;
         2'b10:   r = (x0 & x1) | (x0 & x2) | (x1 & x2);
         default: r = x0 ^ x1 ^ x2;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   logic [1:0]       occ;
   logic [WIDTH-1:0] head_p1;
   logic [WIDTH-1:0] tail_p1;
   logic [WIDTH-1:0] res_p0;
   logic [CNT_W-1:0] hits;
   logic             in_xfer;
   logic             out_xfer;

   // Stage 0: operands evaluated combinationally on the way into the buffer
   assign res_p0    = logic_op(mode, a, b, c);
   assign in_ready  = (occ < 2'd2);
   assign out_valid = (occ != 2'd0);
   assign y         = out_valid ? head_p1 : '0;
   assign hit_count = hits;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   // Stage 1: buffer occupancy and storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ <= 2'd0;
      end else begin
         case ({in_xfer, out_xfer})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Entries are only ever read when occ says they are live, so no data reset
   always_ff @(posedge clk) begin
      if (out_xfer) begin
         head_p1 <= in_xfer ? res_p0 : tail_p1;
      end else if (in_xfer) begin
         if (occ == 2'd0) begin
            head_p1 <= res_p0;
         end else begin
            tail_p1 <= res_p0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits <= '0;
      end else if (cnt_clr) begin
         hits <= '0;
      end else if (out_xfer && (y != '0)) begin
         hits <= sat_inc(hits);
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: queue-based reference model compared every
// falling edge, plus literal checks of the hand-worked scenarios.
module tb_logic_unit_pipe;

   localparam int WIDTH = 8;
   localparam int CNT_W = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a, b, c;
   logic [1:0]       mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             out_ready;
   logic             cnt_clr;
   logic [CNT_W-1:0] hit_count;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] q[$];
   int               mcnt;

   logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .y(y), .out_valid(out_valid),
      .out_ready(out_ready), .cnt_clr(cnt_clr), .hit_count(hit_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference function, evaluated bit by bit from the operand ones-count
   function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] m, input logic [WIDTH-1:0] x0,
                                               input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] x2);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         int n;
         n = int'(x0[i]) + int'(x1[i]) + int'(x2[i]);
         case (m)
            2'b00:   r[i] = (x0[i] && x1[i]) || x2[i];
            2'b01:   r[i] = (x0[i] || x1[i]) && x2[i];
            2'b10:   r[i] = (n >= 2);
            default: r[i] = (n % 2) == 1;
         endcase
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mcnt = 0;
      end else begin
         bit take, give;
         logic [WIDTH-1:0] hd;
         take = in_valid && (q.size() < 2);
         give = out_ready && (q.size() > 0);
         hd   = (q.size() > 0) ? q[0] : '0;
         if (give) void'(q.pop_front());
         if (take) q.push_back(ref_op(mode, a, b, c));
         if (cnt_clr) mcnt = 0;
         else if (give && hd != 0 && mcnt < CNT_MAX) mcnt = mcnt + 1;
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("y", 32'(y), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("hit_count", 32'(hit_count), 32'(mcnt));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [1:0] m, input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc);
      mode = m; a = va; b = vb; c = vc; in_valid = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; a = '0; b = '0; c = '0; mode = 2'b00;
      in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_hit", 32'(hit_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      #2 rst_n = 1'b1;

      // AND-OR with immediate consumer
      put(2'b00, 8'hF0, 8'h3C, 8'h01); out_ready = 1'b1;
      tick();
      chk("m00_valid", 32'(out_valid), 32'd1);
      chk("m00_y", 32'(y), 32'h31);
      in_valid = 1'b0;
      tick();
      chk("m00_hit", 32'(hit_count), 32'd1);
      chk("m00_drained", 32'(out_valid), 32'd0);

      // Majority then XOR back-to-back
      put(2'b10, 8'h0F, 8'h33, 8'h55);
      tick();
      chk("maj_y", 32'(y), 32'h17);
      put(2'b11, 8'h0F, 8'h33, 8'h55);
      tick();
      chk("xor_y", 32'(y), 32'h69);
      in_valid = 1'b0;
      tick();
      chk("seq_hit", 32'(hit_count), 32'd3);

      // Backpressure: three words offered with consumer stalled
      out_ready = 1'b0;
      put(2'b11, 8'h01, 8'h00, 8'h00);
      tick();
      chk("bp_ready1", 32'(in_ready), 32'd1);
      put(2'b11, 8'h02, 8'h00, 8'h00);
      tick();
      chk("bp_ready2", 32'(in_ready), 32'd0);
      chk("bp_head", 32'(y), 32'h01);
      put(2'b11, 8'h04, 8'h00, 8'h00);
      tick();
      chk("bp_hold_y", 32'(y), 32'h01);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_second", 32'(y), 32'h02);
      chk("bp_ready3", 32'(in_ready), 32'd1);
      tick();
      chk("bp_third", 32'(y), 32'h04);
      in_valid = 1'b0;
      tick();
      chk("bp_hit", 32'(hit_count), 32'd6);

      // Reset between edges with the buffer full
      out_ready = 1'b0;
      put(2'b11, 8'h11, 8'h00, 8'h00);
      tick();
      put(2'b11, 8'h22, 8'h00, 8'h00);
      tick();
      in_valid = 1'b0;
      chk("full_ready", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_y", 32'(y), 32'd0);
      chk("mid_rst_hit", 32'(hit_count), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("post_rst_empty", 32'(out_valid), 32'd0);

      // Zero result leaves the counter alone; clear beats increment
      put(2'b11, 8'h01, 8'h00, 8'h00);
      tick();
      put(2'b01, 8'h00, 8'h00, 8'hFF);
      tick();
      chk("zero_y", 32'(y), 32'h00);
      chk("zero_pre_hit", 32'(hit_count), 32'd1);
      in_valid = 1'b0;
      tick();
      chk("zero_hit", 32'(hit_count), 32'd1);
      put(2'b11, 8'h01, 8'h00, 8'h00);
      tick();
      in_valid = 1'b0; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_hit", 32'(hit_count), 32'd0);

      // Saturation: stream enough nonzero results to overrun the counter
      put(2'b11, 8'h5A, 8'h00, 8'h00);
      for (int i = 0; i < CNT_MAX + 4; i++) tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("sat_hit", 32'(hit_count), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
